// File: rtl/iir_cascade_mux.sv
// Time-multiplexed cascade of N_STAGES biquads over N_CH interleaved channels, one shared MAC.
// Build option: define IIR_SAT_EN to saturate the stage output instead of wrapping it.
module iir_cascade_mux #(
  parameter int DATA_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int N_STAGES  = 2,
  parameter int N_CH      = 2,
  parameter int ACC_W     = 40
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  l_r_clk,
  input  logic signed [DATA_W-1:0]              sample_in,
  input  logic                                  coef_we,
  input  logic [$clog2(N_STAGES*5)-1:0]         coef_addr,
  input  logic signed [DATA_W-1:0]              coef_data,
  output logic signed [DATA_W-1:0]              filtered_output,
  output logic                                  out_valid,
  output logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] out_ch,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam int NCOEF = N_STAGES * 5;
  localparam int AW    = $clog2(NCOEF);
  localparam int CW    = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int SW    = N_STAGES > 1 ? $clog2(N_STAGES) : 1;
  localparam int PW    = 2 * DATA_W;

  localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(N_STAGES - 1);
  localparam logic signed [ACC_W-1:0] RND =
    ACC_W'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [DATA_W-1:0] ONE =
    DATA_W'(1) <<< COEF_FRAC;

  typedef enum logic [2:0] {
    IDLE, LOAD, MAC, WB, DONE
  } state_t;

  state_t state;

  logic                     d1, d2;
  logic                     l_r_edge;
  logic                     accept;
  logic [CW-1:0]            ch_cnt;
  logic [CW-1:0]            cur_ch;
  logic [SW-1:0]            stage;
  logic [2:0]               tap;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [DATA_W-1:0] x_cur;
  logic signed [DATA_W-1:0] op;
  logic signed [DATA_W-1:0] coef;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [DATA_W-1:0] y_red;
  logic [AW-1:0]            cidx;

  logic signed [DATA_W-1:0] coef_q [NCOEF];
  logic signed [DATA_W-1:0] hx1 [N_CH][N_STAGES];
  logic signed [DATA_W-1:0] hx2 [N_CH][N_STAGES];
  logic signed [DATA_W-1:0] hy1 [N_CH][N_STAGES];
  logic signed [DATA_W-1:0] hy2 [N_CH][N_STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= l_r_clk;
      d2 <= d1;
    end
  end

  assign l_r_edge = d1 ^ d2;
  assign accept   = l_r_edge & ~busy;
  assign overrun  = l_r_edge & busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCOEF; i++)
        coef_q[i] <= (i % 5 == 0) ? ONE : '0;
    end else if (coef_we && !busy && 32'(coef_addr) < NCOEF) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  assign cidx = AW'(32'(stage) * 5 + 32'(tap));
  assign coef = coef_q[cidx];

  always_comb begin
    op = x_cur;
    unique case (1'b1)
      tap == 3'd1: op = hx1[cur_ch][stage];
      tap == 3'd2: op = hx2[cur_ch][stage];
      tap == 3'd3: op = hy1[cur_ch][stage];
      tap == 3'd4: op = hy2[cur_ch][stage];
      default:     op = x_cur;
    endcase
  end

  // feedback taps subtract the product so a -2.0 coefficient never has to be negated
  assign prod     = coef * op;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign acc_nxt  = (tap >= 3'd3) ? acc - prod_ext : acc + prod_ext;

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] rnd;

  always_comb begin
    rnd = (acc + RND) >>> COEF_FRAC;
    if (rnd > SMAX)
      y_red = SMAX[DATA_W-1:0];
    else if (rnd < SMIN)
      y_red = SMIN[DATA_W-1:0];
    else
      y_red = rnd[DATA_W-1:0];
  end
`else
  always_comb begin
    y_red = DATA_W'((acc + RND) >>> COEF_FRAC);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      ch_cnt          <= '0;
      cur_ch          <= '0;
      stage           <= '0;
      tap             <= '0;
      acc             <= '0;
      x_cur           <= '0;
      busy            <= 1'b0;
      out_valid       <= 1'b0;
      out_ch          <= '0;
      filtered_output <= '0;
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < N_STAGES; s++) begin
          hx1[c][s] <= '0;
          hx2[c][s] <= '0;
          hy1[c][s] <= '0;
          hy2[c][s] <= '0;
        end
    end else begin
      out_valid <= 1'b0;
      if (l_r_edge)
        ch_cnt <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
      if (out_valid)
        busy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            x_cur  <= sample_in;
            cur_ch <= ch_cnt;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          acc   <= '0;
          stage <= '0;
          tap   <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_nxt;
          if (tap == 3'd4) begin
            tap   <= '0;
            state <= WB;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        WB: begin
          hx2[cur_ch][stage] <= hx1[cur_ch][stage];
          hx1[cur_ch][stage] <= x_cur;
          hy2[cur_ch][stage] <= hy1[cur_ch][stage];
          hy1[cur_ch][stage] <= y_red;
          x_cur <= y_red;
          acc   <= '0;
          if (stage == ST_LAST) begin
            state <= DONE;
          end else begin
            stage <= stage + 1'b1;
            state <= MAC;
          end
        end
        DONE: begin
          filtered_output <= x_cur;
          out_ch          <= cur_ch;
          out_valid       <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_cascade_mux.sv
// Scoreboard bench for iir_cascade_mux at default parameters.
// Directed vectors push expected outputs; a monitor pops them on out_valid.
module tb_iir_cascade_mux;

  localparam int N_STAGES = 2;
  localparam int LAT      = 4 + 6 * N_STAGES;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        l_r_clk = 1'b0;
  logic [15:0] sample_in = '0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic [15:0] filtered_output;
  logic        out_valid;
  logic [0:0]  out_ch;
  logic        busy;
  logic        overrun;

  iir_cascade_mux dut (
    .clk(clk),
    .reset(reset),
    .l_r_clk(l_r_clk),
    .sample_in(sample_in),
    .coef_we(coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .filtered_output(filtered_output),
    .out_valid(out_valid),
    .out_ch(out_ch),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic        ch;
    int          at;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int ov_cnt  = 0;

  task automatic chk(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)",
               name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && overrun) ov_cnt++;
    if (reset && out_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got data 0x%0h ch %0d, expected none",
                 filtered_output, out_ch);
      end else begin
        e = q.pop_front();
        chk("data", int'(filtered_output), int'(e.d));
        chk("out_ch", int'(out_ch), int'(e.ch));
        chk("latency_cycle", cyc, e.at);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    chk("queue_drained", q.size(), 0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    l_r_clk = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_filtered_output", int'(filtered_output), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    ov_cnt = 0;
  endtask

  task automatic wr(logic [3:0] a, logic [15:0] d);
    @(posedge clk);
    #1;
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic send(logic [15:0] d, logic exp_on,
                      logic [15:0] y, logic ch);
    @(posedge clk);
    #1;
    l_r_clk   = ~l_r_clk;
    sample_in = d;
    if (exp_on) q.push_back('{y, ch, cyc + LAT});
  endtask

  logic [15:0] imp_in  [3];
  logic [15:0] imp_out [3];
  logic [15:0] sat_exp;

  initial begin
    imp_in  = '{16'h1000, 16'h0000, 16'h0000};
    imp_out = '{16'h1000, 16'h0800, 16'h0400};
`ifdef IIR_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hDFFE;
`endif

    do_reset();
    send(16'h1234, 1'b1, 16'h1234, 1'b0);
    idle(20);
    send(16'h8001, 1'b1, 16'h8001, 1'b1);
    idle(20);
    chk("no_overrun_passthru", ov_cnt, 0);

    do_reset();
    wr(4'd0, 16'h2000);
    send(16'h4000, 1'b1, 16'h2000, 1'b0);
    idle(20);

    do_reset();
    wr(4'd0, 16'h4000);
    wr(4'd3, 16'hE000);
    for (int i = 0; i < 3; i++) begin
      send(imp_in[i], 1'b1, imp_out[i], 1'b0);
      idle(20);
      send(16'h0000, 1'b1, 16'h0000, 1'b1);
      idle(20);
    end

    do_reset();
    wr(4'd0, 16'h7FFF);
    send(16'h7000, 1'b1, sat_exp, 1'b0);
    idle(20);

    do_reset();
    send(16'h0300, 1'b1, 16'h0300, 1'b0);
    idle(4);
    send(16'h0700, 1'b0, 16'h0000, 1'b0);
    idle(1);
    wr(4'd0, 16'h2000);
    idle(25);
    chk("overrun_count", ov_cnt, 1);
    send(16'h0500, 1'b1, 16'h0500, 1'b0);
    idle(20);

    do_reset();
    wr(4'd0, 16'h2000);
    send(16'h0400, 1'b0, 16'h0000, 1'b0);
    repeat (7) @(posedge clk);
    do_reset();
    idle(20);
    send(16'h0100, 1'b1, 16'h0100, 1'b0);
    idle(20);

    chk("final_queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
